// File: rtl/pc_gen.sv
// Fetch PC register with a direct-mapped BTB and 2-bit counters.
// Resolves execute-stage branches and drives the redirect on mispredict.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   Stall               hold Pc (overridden by Mispredict)
//   Pc                  registered fetch address
//   Pred_taken          BTB predicts a taken transfer at Pc
//   Pred_target         predicted next fetch address
//   Res_*               resolved control-transfer from execute
//   Mispredict          resolve disagrees with the carried prediction
//   Redirect_pc         correct next PC of the resolving instruction
module pc_gen #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BTB_ENTRIES = 16,
    parameter int              IMM_SHIFT   = 1,
    parameter int              INST_BYTES  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall,
    output logic [XLEN-1:0] Pc,
    output logic            Pred_taken,
    output logic [XLEN-1:0] Pred_target,
    input  logic            Res_valid,
    input  logic [XLEN-1:0] Res_pc,
    input  logic            Res_taken,
    input  logic            Res_jalr,
    input  logic [XLEN-1:0] Res_imm,
    input  logic [XLEN-1:0] Res_rs1,
    input  logic            Res_pred_taken,
    input  logic [XLEN-1:0] Res_pred_target,
    output logic            Mispredict,
    output logic [XLEN-1:0] Redirect_pc
);

    localparam int              IDX_W = $clog2(BTB_ENTRIES);
    localparam int              TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic             valid_q [BTB_ENTRIES];
    logic             valid_d [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_d   [BTB_ENTRIES];
    logic [XLEN-1:0]  tgt_q   [BTB_ENTRIES];
    logic [XLEN-1:0]  tgt_d   [BTB_ENTRIES];
    logic [1:0]       cnt_q   [BTB_ENTRIES];
    logic [1:0]       cnt_d   [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;
    logic [XLEN-1:0]  base, sum, tgt;
    logic             unused_low_bits;

    // Low two bits never select an entry; instructions are word aligned.
    assign unused_low_bits = ^{pc_q[1:0], Res_pc[1:0]};

    assign lk_idx = pc_q[IDX_W+1:2];
    assign lk_tag = pc_q[XLEN-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign up_idx = Res_pc[IDX_W+1:2];
    assign up_tag = Res_pc[XLEN-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign Pc          = pc_q;
    assign Pred_taken  = lk_hit && cnt_q[lk_idx][1];
    assign Pred_target = Pred_taken ? tgt_q[lk_idx] : pc_q + STEP;

    // Target arithmetic wraps modulo 2^XLEN; jalr clears bit 0.
    always_comb begin
        base = Res_jalr ? Res_rs1 : Res_pc;
        sum  = base + (Res_imm << IMM_SHIFT);
        tgt  = sum;
        if (Res_jalr) begin
            tgt[0] = 1'b0;
        end
    end

    assign Redirect_pc = Res_taken ? tgt : Res_pc + STEP;
    assign Mispredict  = Res_valid &&
                         ((Res_taken != Res_pred_taken) ||
                          (Res_taken && (tgt != Res_pred_target)));

    always_comb begin
        pc_d = Pred_target;
        if (Mispredict) begin
            pc_d = Redirect_pc;
        end else if (Stall) begin
            pc_d = pc_q;
        end
    end

    // Update is independent of Stall; a taken miss evicts the occupant.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (Res_valid) begin
            if (up_hit) begin
                if (Res_taken) begin
                    if (cnt_q[up_idx] != 2'd3) begin
                        cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
                    end
                    tgt_d[up_idx] = tgt;
                end else if (cnt_q[up_idx] != 2'd0) begin
                    cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
                end
            end else if (Res_taken) begin
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = tgt;
                cnt_d[up_idx]   = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= 2'd0;
            end
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with a 4-entry BTB.
// Expected values are hand-computed per vector.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        Stall;
    logic [31:0] Pc;
    logic        Pred_taken;
    logic [31:0] Pred_target;
    logic        Res_valid;
    logic [31:0] Res_pc;
    logic        Res_taken;
    logic        Res_jalr;
    logic [31:0] Res_imm;
    logic [31:0] Res_rs1;
    logic        Res_pred_taken;
    logic [31:0] Res_pred_target;
    logic        Mispredict;
    logic [31:0] Redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    pc_gen #(
        .XLEN        (32),
        .RESET_PC    (32'h0),
        .BTB_ENTRIES (4),
        .IMM_SHIFT   (1),
        .INST_BYTES  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Stall           (Stall),
        .Pc              (Pc),
        .Pred_taken      (Pred_taken),
        .Pred_target     (Pred_target),
        .Res_valid       (Res_valid),
        .Res_pc          (Res_pc),
        .Res_taken       (Res_taken),
        .Res_jalr        (Res_jalr),
        .Res_imm         (Res_imm),
        .Res_rs1         (Res_rs1),
        .Res_pred_taken  (Res_pred_taken),
        .Res_pred_target (Res_pred_target),
        .Mispredict      (Mispredict),
        .Redirect_pc     (Redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Res_valid = 1'b0;
        #1;
    endtask

    task automatic res(input logic [31:0] pc, input logic taken,
                       input logic jalr, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic pt,
                       input logic [31:0] ptgt);
        Res_pc          = pc;
        Res_taken       = taken;
        Res_jalr        = jalr;
        Res_imm         = imm;
        Res_rs1         = rs1;
        Res_pred_taken  = pt;
        Res_pred_target = ptgt;
        Res_valid       = 1'b1;
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        Stall = 1'b0;
        res(0, 0, 0, 0, 0, 0, 0);
        Res_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst_pc", Pc, 32'h0);
        check("rst_pt", Pred_taken, 0);
        check("rst_ptgt", Pred_target, 32'h4);
        check("rst_mp", Mispredict, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("seq_pc", Pc, 32'(4 * i));
            check("seq_pt", Pred_taken, 0);
        end
        #2 rst = 1'b1;
        #1 check("async_rst", Pc, 32'h0);
        #2 rst = 1'b0;

        // taken miss allocates 0x40 -> 0x60
        res(32'h40, 1, 0, 32'h10, 0, 0, 32'h44);
        check("t2_mp", Mispredict, 1);
        check("t2_redir", Redirect_pc, 32'h60);
        step(); idle();
        check("t2_pc", Pc, 32'h60);
        res(32'h3C, 1, 0, 32'h2, 0, 0, 32'h40);
        check("t2_redir40", Redirect_pc, 32'h40);
        step(); idle();
        check("t2_pc40", Pc, 32'h40);
        check("t2_hit_pt", Pred_taken, 1);
        check("t2_hit_tgt", Pred_target, 32'h60);
        step();
        check("t2_follow", Pc, 32'h60);

        // train down 2 -> 1 -> 0
        res(32'h40, 0, 0, 32'h10, 0, 1, 32'h60);
        check("t3_mp", Mispredict, 1);
        check("t3_redir", Redirect_pc, 32'h44);
        step(); idle();
        check("t3_pc", Pc, 32'h44);
        res(32'h40, 0, 0, 32'h10, 0, 0, 32'h44);
        check("t3_nomp", Mispredict, 0);
        step(); idle();
        check("t3_seq", Pc, 32'h48);
        res(32'h3C, 1, 0, 32'h2, 0, 0, 32'h40);
        step(); idle();
        check("t3_pc40", Pc, 32'h40);
        check("t3_pt0", Pred_taken, 0);
        check("t3_ptgt", Pred_target, 32'h44);
        res(32'h40, 0, 0, 32'h10, 0, 0, 32'h44);
        step();
        res(32'h40, 1, 0, 32'h10, 0, 0, 32'h44);
        check("t3_up_mp", Mispredict, 1);
        step();
        res(32'h3C, 1, 0, 32'h2, 0, 0, 32'h40);
        step(); idle();
        check("t3_pc40b", Pc, 32'h40);
        check("t3_satlow", Pred_taken, 0);

        // jalr: 0x1001 + (4<<1) = 0x1009 -> 0x1008
        res(32'h80, 1, 1, 32'h4, 32'h1001, 1, 32'h1009);
        check("t4_badtgt", Mispredict, 1);
        Res_pred_target = 32'h1008;
        #1;
        check("t4_mp", Mispredict, 0);
        check("t4_redir", Redirect_pc, 32'h1008);
        step(); idle();

        // stall vs mispredict
        Stall = 1'b1;
        res(32'h100, 1, 0, 32'h80, 0, 0, 32'h104);
        check("t5_redir", Redirect_pc, 32'h200);
        step(); idle();
        check("t5_pc", Pc, 32'h200);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_hold", Pc, 32'h200);
        end
        Stall = 1'b0;
        step();
        check("t5_resume", Pc, 32'h204);
        res(32'hFC, 1, 0, 32'h2, 0, 0, 32'h100);
        step(); idle();
        check("t5_pc100", Pc, 32'h100);
        check("t5_stall_upd_pt", Pred_taken, 1);
        check("t5_stall_upd_tgt", Pred_target, 32'h200);

        // reset clears BTB; wrap and aliasing
        rst = 1'b1;
        #1 check("t6_rst", Pc, 32'h0);
        #1 rst = 1'b0;
        res(32'hFC, 0, 0, 32'h2, 0, 1, 32'h100);
        check("t6_nt_redir", Redirect_pc, 32'h100);
        step(); idle();
        check("t6_pc100", Pc, 32'h100);
        check("t6_btb_clr", Pred_taken, 0);
        res(32'hFFFFFFFC, 1, 0, 32'h4, 0, 0, 32'h0);
        check("t6_wrap_mp", Mispredict, 1);
        check("t6_wrap", Redirect_pc, 32'h4);
        step(); idle();
        check("t6_pc4", Pc, 32'h4);
        res(32'h0, 1, 0, 32'h20, 0, 0, 32'h4);
        step(); idle();
        check("t6_pc40", Pc, 32'h40);
        res(32'h10, 1, 0, 32'h40, 0, 0, 32'h14);
        step(); idle();
        check("t6_pc90", Pc, 32'h90);
        res(32'hFFFFFFFC, 0, 0, 32'h4, 0, 1, 32'h4);
        check("t6_nt_wrap", Redirect_pc, 32'h0);
        step(); idle();
        check("t6_pc0", Pc, 32'h0);
        check("t6_evict_pt", Pred_taken, 0);
        check("t6_evict_tgt", Pred_target, 32'h4);
        res(32'hC, 0, 0, 32'h0, 0, 1, 32'h10);
        step(); idle();
        check("t6_pc10", Pc, 32'h10);
        check("t6_alias_pt", Pred_taken, 1);
        check("t6_alias_tgt", Pred_target, 32'h90);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
